// File: rtl/reg_bank_8.sv
// reg_bank_8: eight-entry general register bank driven by a valid/ready
// command interface. Each register feeds one input of the downstream bus mux.
// Only one register can be written per clock. SWAP therefore takes two
// cycles, and the second write comes from an internal temp register.
//
// Handshake: a command transfers on a rising edge where cmd_valid & cmd_ready.
// All command fields are sampled on that edge only. cmd_ready is low only in
// SWAP2. The issuer holds the command stable until it transfers. done is a
// registered one-cycle pulse per completed command.
module reg_bank_8 #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [2:0]       cmd_a,
    input  logic [2:0]       cmd_b,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             done,
    output logic             wrap,
    output logic [WIDTH-1:0] r0,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] r3,
    output logic [WIDTH-1:0] r4,
    output logic [WIDTH-1:0] r5,
    output logic [WIDTH-1:0] r6,
    output logic [WIDTH-1:0] r7,
    output logic             state_dbg
);

    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_MOVE = 3'b100;
    localparam logic [2:0] OP_SWAP = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;

    typedef enum logic {IDLE = 1'b0, SWAP2 = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] regs_q [8];
    logic [WIDTH-1:0] temp_q, temp_d;
    logic [2:0]       b_save_q, b_save_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;

    // Single shared write port into the register array
    logic             wr_en;
    logic [2:0]       wr_idx;
    logic [WIDTH-1:0] wr_val;

    logic             accept;
    logic [WIDTH-1:0] cur_a, cur_b;

    assign cmd_ready = (state_q == IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign cur_a     = regs_q[cmd_a];
    assign cur_b     = regs_q[cmd_b];

    // Next-state, write-port and flag decode for the current state and command
    always_comb begin
        state_d  = state_q;
        temp_d   = temp_q;
        b_save_d = b_save_q;
        done_d   = 1'b0;
        wrap_d   = wrap_q;
        wr_en    = 1'b0;
        wr_idx   = cmd_a;
        wr_val   = cmd_data;
        case (state_q)
            SWAP2: begin
                // Second half of SWAP: old r[a] lands in r[b]
                wr_en   = 1'b1;
                wr_idx  = b_save_q;
                wr_val  = temp_q;
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: begin
                if (accept) begin
                    done_d = 1'b1;
                    case (cmd_op)
                        OP_LOAD: begin
                            wr_en  = 1'b1;
                            wr_val = cmd_data;
                        end
                        OP_INC: begin
                            wr_en  = 1'b1;
                            wr_val = cur_a + WIDTH'(1);
                            wrap_d = (cur_a == {WIDTH{1'b1}});
                        end
                        OP_DEC: begin
                            wr_en  = 1'b1;
                            wr_val = cur_a - WIDTH'(1);
                            wrap_d = (cur_a == '0);
                        end
                        OP_MOVE: begin
                            wr_en  = 1'b1;
                            wr_val = cur_b;
                        end
                        OP_SWAP: begin
                            wr_en    = 1'b1;
                            wr_val   = cur_b;
                            temp_d   = cur_a;
                            b_save_d = cmd_b;
                            state_d  = SWAP2;
                            done_d   = 1'b0;
                        end
                        OP_CLR: begin
                            wr_en  = 1'b1;
                            wr_val = '0;
                        end
                        default: ; // NOP and reserved opcode
                    endcase
                end
            end
        endcase
    end

    // State, flags, temp and the register array; reset aborts any pending SWAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            temp_q   <= '0;
            b_save_q <= '0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
            for (int i = 0; i < 8; i++) regs_q[i] <= RESET_VAL;
        end else begin
            state_q  <= state_d;
            temp_q   <= temp_d;
            b_save_q <= b_save_d;
            done_q   <= done_d;
            wrap_q   <= wrap_d;
            if (wr_en) regs_q[wr_idx] <= wr_val;
        end
    end

    assign done      = done_q;
    assign wrap      = wrap_q;
    assign state_dbg = state_q;
    assign r0 = regs_q[0];
    assign r1 = regs_q[1];
    assign r2 = regs_q[2];
    assign r3 = regs_q[3];
    assign r4 = regs_q[4];
    assign r5 = regs_q[5];
    assign r6 = regs_q[6];
    assign r7 = regs_q[7];

endmodule

// File: tb/tb_reg_bank_8.sv
// Bench for reg_bank_8: directed commands, a register/wrap snapshot model
// feeding an expected queue, and a done-driven monitor.
module tb_reg_bank_8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op, cmd_a, cmd_b;
  logic [7:0] cmd_data;
  logic       done, wrap, state_dbg;
  logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7;

  int total = 0;
  int bad   = 0;

  logic [64:0] exp_q[$];
  logic [7:0]  m_regs [8];
  logic        m_wrap;
  int          run_cur = 0;
  int          run_max = 0;

  reg_bank_8 #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_data(cmd_data),
    .done(done), .wrap(wrap),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [64:0] dut_snap();
    return {wrap, r7, r6, r5, r4, r3, r2, r1, r0};
  endfunction

  function automatic logic [64:0] model_snap();
    return {m_wrap, m_regs[7], m_regs[6], m_regs[5], m_regs[4],
            m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
  endfunction

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_wrap = 1'b0;
  endtask

  // Driver: present at negedge, wait (bounded) for ready, transfer at posedge
  task automatic issue(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                       input logic [7:0] data, output int waits);
    logic [7:0] t;
    waits = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_data = data;
    while (!cmd_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1 within 20 cycles");
    end
    @(posedge clk);
    case (op)
      3'b001: m_regs[a] = data;
      3'b010: begin m_wrap = (m_regs[a] == 8'hFF); m_regs[a] = m_regs[a] + 8'h01; end
      3'b011: begin m_wrap = (m_regs[a] == 8'h00); m_regs[a] = m_regs[a] - 8'h01; end
      3'b100: m_regs[a] = m_regs[b];
      3'b101: begin t = m_regs[a]; m_regs[a] = m_regs[b]; m_regs[b] = t; end
      3'b110: m_regs[a] = 8'h00;
      default: ;
    endcase
    exp_q.push_back(model_snap());
    #1;
    cmd_valid = 1'b0;
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    chk({tag, "_regs"}, dut_snap(), 65'd0);
    chk({tag, "_ready"}, {64'd0, cmd_ready}, 65'd1);
    chk({tag, "_done"}, {64'd0, done}, 65'd0);
    chk({tag, "_state"}, {64'd0, state_dbg}, 65'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: each done pulse pops one expected snapshot
  always @(negedge clk) begin
    if (rst_n && done) begin
      run_cur++;
      if (run_cur > run_max) run_max = run_cur;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_done: got done=1 expected no pending command");
      end else begin
        chk("done_snapshot", dut_snap(), exp_q.pop_front());
      end
    end else begin
      run_cur = 0;
    end
  end

  initial begin
    int w;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 3'd0; cmd_b = 3'd0; cmd_data = 8'h00;
    model_reset();
    #2;
    chk("init_regs", dut_snap(), 65'd0);
    chk("init_ready", {64'd0, cmd_ready}, 65'd1);
    chk("init_done", {64'd0, done}, 65'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // LOAD then MOVE back-to-back
    run_max = 0;
    issue(3'b001, 3'd3, 3'd0, 8'hA5, w);
    issue(3'b100, 3'd6, 3'd3, 8'h00, w);
    chk("move_r6", {57'd0, r6}, {57'd0, 8'hA5});
    chk("move_r3", {57'd0, r3}, {57'd0, 8'hA5});
    @(negedge clk); #1;
    chk("done_run2", 65'(run_max), 65'd2);

    // Wrap behaviour
    issue(3'b001, 3'd1, 3'd0, 8'hFF, w);
    issue(3'b010, 3'd1, 3'd0, 8'h00, w);
    chk("inc_ff_r1", {57'd0, r1}, {57'd0, 8'h00});
    chk("inc_ff_wrap", {64'd0, wrap}, 65'd1);
    issue(3'b011, 3'd1, 3'd0, 8'h00, w);
    chk("dec_00_r1", {57'd0, r1}, {57'd0, 8'hFF});
    chk("dec_00_wrap", {64'd0, wrap}, 65'd1);
    issue(3'b010, 3'd1, 3'd0, 8'h00, w);
    chk("inc_again_r1", {57'd0, r1}, {57'd0, 8'h00});
    issue(3'b001, 3'd2, 3'd0, 8'h10, w);
    chk("load_keeps_wrap", {64'd0, wrap}, 65'd1);
    issue(3'b010, 3'd2, 3'd0, 8'h00, w);
    chk("inc_r2", {57'd0, r2}, {57'd0, 8'h11});
    chk("inc_nowrap", {64'd0, wrap}, 65'd0);

    // SWAP with a command held during SWAP2
    issue(3'b001, 3'd0, 3'd0, 8'h12, w);
    issue(3'b001, 3'd7, 3'd0, 8'h34, w);
    issue(3'b101, 3'd0, 3'd7, 8'h00, w);
    chk("swap_ready_low", {64'd0, cmd_ready}, 65'd0);
    chk("swap_state", {64'd0, state_dbg}, 65'd1);
    chk("swap_no_early_done", {64'd0, done}, 65'd0);
    chk("swap_half_r0", {57'd0, r0}, {57'd0, 8'h34});
    issue(3'b001, 3'd5, 3'd0, 8'h77, w);
    chk("held_cmd_waits", 65'(w), 65'd1);
    chk("swap_r0", {57'd0, r0}, {57'd0, 8'h34});
    chk("swap_r7", {57'd0, r7}, {57'd0, 8'h12});
    chk("held_load_r5", {57'd0, r5}, {57'd0, 8'h77});

    // SWAP a==b: two cycles, no change
    issue(3'b101, 3'd3, 3'd3, 8'h00, w);
    chk("swap_same_ready", {64'd0, cmd_ready}, 65'd0);

    // Reserved opcode
    issue(3'b111, 3'd2, 3'd0, 8'h55, w);
    chk("rsvd_r2", {57'd0, r2}, {57'd0, 8'h11});
    chk("rsvd_wrap", {64'd0, wrap}, 65'd0);
    issue(3'b110, 3'd6, 3'd0, 8'h00, w);
    chk("clr_r6", {57'd0, r6}, {57'd0, 8'h00});

    // Reset mid-cycle after loads
    #2;
    do_reset("rst_idle");

    // Reset while in SWAP2
    issue(3'b001, 3'd1, 3'd0, 8'h5A, w);
    issue(3'b101, 3'd1, 3'd2, 8'h00, w);
    #2;
    do_reset("rst_swap2");
    repeat (3) @(negedge clk);

    // Bank operates normally after reset
    issue(3'b011, 3'd0, 3'd0, 8'h00, w);
    chk("post_rst_dec_r0", {57'd0, r0}, {57'd0, 8'hFF});
    chk("post_rst_dec_wrap", {64'd0, wrap}, 65'd1);

    // Drain scoreboard (bounded)
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain", 65'(exp_q.size()), 65'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
